// File: rtl/pc_stack_sequencer_if.sv
// Fetch-stage program-counter bus between the sequencer and its user.
//   Requester side (master): drives En, Op, DIn, ClrErr.
//   Sequencer side (slave):  drives DOut (current PC), Depth, Full, Empty,
//                            Overflow, Underflow.
interface pc_stack_sequencer_if #(
  parameter int unsigned DataWidth  = 16,
  parameter int unsigned StackDepth = 8
);
  localparam int unsigned SW = $clog2(StackDepth + 1);

  logic                 En;
  logic [2:0]           Op;
  logic [DataWidth-1:0] DIn;
  logic                 ClrErr;
  logic [DataWidth-1:0] DOut;
  logic [SW-1:0]        Depth;
  logic                 Full;
  logic                 Empty;
  logic                 Overflow;
  logic                 Underflow;

  modport master (
    output En, Op, DIn, ClrErr,
    input  DOut, Depth, Full, Empty, Overflow, Underflow
  );

  modport slave (
    input  En, Op, DIn, ClrErr,
    output DOut, Depth, Full, Empty, Overflow, Underflow
  );
endinterface

// File: rtl/pc_stack_sequencer.sv
// Program counter with auto-increment, absolute load, PC-relative branch and a
// hardware call/return stack with sticky overflow/underflow flags.
//   Clk   : clock, all state changes on the rising edge
//   Reset : synchronous, active-low
//   bus   : slave side of pc_stack_sequencer_if (En/Op/DIn/ClrErr in;
//           DOut/Depth/Full/Empty/Overflow/Underflow out)
module pc_stack_sequencer #(
  parameter int unsigned DataWidth    = 16,
  parameter int unsigned WordByteSize = 2,
  parameter int unsigned StackDepth   = 8,
  parameter int unsigned ResetVector  = 0
) (
  input logic                 Clk,
  input logic                 Reset,
  pc_stack_sequencer_if.slave bus
);
  localparam int unsigned SW = $clog2(StackDepth + 1);
  localparam int unsigned IW = $clog2(StackDepth);

  localparam logic [2:0] OP_INC    = 3'b000;
  localparam logic [2:0] OP_LOAD   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [DataWidth-1:0] pc_q, pc_d;
  logic [SW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [DataWidth-1:0] stack_q [StackDepth];

  logic                 full;
  logic                 empty;
  logic                 push_en;
  logic                 set_ovf;
  logic                 set_unf;
  logic [DataWidth-1:0] ret_addr;

  // Status decoded from the Depth register only
  assign full     = (depth_q == SW'(StackDepth));
  assign empty    = (depth_q == SW'(0));
  assign ret_addr = pc_q + DataWidth'(WordByteSize);

  // Next-state decode of the current operation
  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    push_en = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    if (bus.En) begin
      case (bus.Op)
        OP_INC:    pc_d = ret_addr;
        OP_LOAD:   pc_d = bus.DIn;
        // Two's-complement add at full width is the signed branch
        OP_BRANCH: pc_d = pc_q + bus.DIn;
        OP_CALL: begin
          if (full) begin
            set_ovf = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + SW'(1);
            pc_d    = bus.DIn;
          end
        end
        OP_RET: begin
          if (empty) begin
            set_unf = 1'b1;
          end else begin
            pc_d    = stack_q[IW'(depth_q - SW'(1))];
            depth_d = depth_q - SW'(1);
          end
        end
        default: ;
      endcase
    end
    // A set event in the same cycle outranks the clear
    ovf_d = set_ovf | (ovf_q & ~bus.ClrErr);
    unf_d = set_unf | (unf_q & ~bus.ClrErr);
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q    <= DataWidth'(ResetVector);
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents survive reset, only Depth is cleared
  always_ff @(posedge Clk) begin
    if (Reset && push_en) begin
      stack_q[IW'(depth_q)] <= ret_addr;
    end
  end

  assign bus.DOut      = pc_q;
  assign bus.Depth     = depth_q;
  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
endmodule
